// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store control between MEM stage and a 1-cycle-latency data RAM
module lsu_mem_ctrl #(
  parameter int unsigned RAM_BYTES = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic [31:0] rsp_badaddr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [2:0]  mem_size_o,
  input  logic [31:0] mem_data_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic        we_q, first_q;
  logic [1:0]  err_q;
  logic [31:0] addr_q, maddr_q, mdata_q, hold_q;
  logic [2:0]  msize_q;
  logic        illegal, misal, oor, accept;
  logic [1:0]  cls_err;
  logic [32:0] nbytes, off33, end33;
  assign illegal = req_size_i == 3'b011 || req_size_i[2:1] == 2'b11 || (req_we_i && req_size_i[2]);
  assign misal   = (req_size_i[1:0] == 2'b01 && req_addr_i[0]) ||
                   (req_size_i == 3'b010 && req_addr_i[1:0] != 2'b00);
  assign nbytes  = req_size_i[1] ? 33'd4 : req_size_i[0] ? 33'd2 : 33'd1;
  // 33-bit range arithmetic keeps a wrapped end address from looking in-range
  assign off33   = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
  assign end33   = off33 + nbytes;
  assign oor     = req_addr_i < BASE_ADDR || end33 > 33'(RAM_BYTES);
  assign cls_err = (illegal || misal) ? 2'b01 : oor ? 2'b10 : 2'b00;
  assign accept  = state_q == IDLE && req_valid_i;
  assign mem_addr_o    = maddr_q;
  assign mem_data_o    = mdata_q;
  assign mem_size_o    = msize_q;
  assign mem_we_o      = state_q == ACCESS && we_q && !rst;
  assign mem_re_o      = state_q == ACCESS && !we_q && !rst;
  assign rsp_err_o     = state_q == RESP ? err_q : 2'b00;
  assign rsp_badaddr_o = (state_q == RESP && err_q != 2'b00) ? addr_q : 32'h0;
  assign rsp_rdata_o   = (state_q == RESP && err_q == 2'b00 && !we_q) ? (first_q ? mem_data_i : hold_q) : 32'h0;
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        state_d     = req_valid_i ? (cls_err != 2'b00 ? RESP : ACCESS) : IDLE;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = rsp_ready_i ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // request capture; RAM-side registers only move for requests that will reach the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 2'b00;
      addr_q  <= 32'h0;
      maddr_q <= 32'h0;
      mdata_q <= 32'h0;
      msize_q <= 3'b000;
      first_q <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q   <= req_we_i;
        err_q  <= cls_err;
        addr_q <= req_addr_i;
        if (cls_err == 2'b00) begin
          maddr_q <= req_addr_i - BASE_ADDR;
          mdata_q <= req_wdata_i;
          msize_q <= req_size_i;
        end
      end
      first_q <= state_q == ACCESS && !we_q;
      if (first_q) hold_q <= mem_data_i;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench with a transaction-level reference model and RAM model
module tb_lsu_mem_ctrl;
  localparam int N = 8192;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [2:0] req_size_i = 3'b0;
  logic [31:0] req_addr_i = 32'h0, req_wdata_i = 32'h0;
  logic rsp_valid_o, rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o, rsp_badaddr_o, mem_addr_o, mem_data_o;
  logic [1:0] rsp_err_o;
  logic mem_we_o, mem_re_o;
  logic [2:0] mem_size_o;
  logic [31:0] mem_data_i = 32'h0;
  int n_vec = 0, n_miss = 0;

  lsu_mem_ctrl #(.RAM_BYTES(N), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_badaddr_o(rsp_badaddr_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_size_o(mem_size_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return sz[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return sz[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // RAM driven only by the DUT's memory port
  logic [7:0] ram [N];
  initial for (int i = 0; i < N; i++) ram[i] = 8'h0;
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr_o % N);
    if (mem_we_o)
      for (int i = 0; i < (1 << mem_size_o[1:0]); i++) ram[(a + i) % N] = mem_data_o[8*i +: 8];
    if (mem_re_o)
      mem_data_i <= ext({ram[(a+3)%N], ram[(a+2)%N], ram[(a+1)%N], ram[a]}, mem_size_o);
  end

  // reference model: expected memory plus the current transaction's phase
  logic [7:0] mm [N];
  initial for (int i = 0; i < N; i++) mm[i] = 8'h0;
  int ph = 0;
  logic m_we;
  logic [2:0] m_size;
  logic [31:0] m_addr, m_wd, m_rd, m_bad;
  logic [1:0] m_err;

  function automatic logic [1:0] classify(input logic we, input logic [2:0] sz, input logic [31:0] a);
    longint nb;
    nb = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    if (sz == 3 || sz == 6 || sz == 7 || (we && sz >= 4)) return 2'b01;
    if ((a % nb) != 0) return 2'b01;
    if (longint'(a) + nb > longint'(N)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (rst) ph = 0;
    else if (ph == 0) begin
      if (req_valid_i) begin
        m_we = req_we_i; m_size = req_size_i; m_addr = req_addr_i; m_wd = req_wdata_i;
        m_err = classify(m_we, m_size, m_addr);
        m_bad = (m_err != 0) ? m_addr : 32'h0;
        m_rd = (m_err == 0 && !m_we) ?
          ext({mm[(m_addr+3)%N], mm[(m_addr+2)%N], mm[(m_addr+1)%N], mm[m_addr%N]}, m_size) : 32'h0;
        ph = (m_err != 0) ? 2 : 1;
      end
    end else if (ph == 1) begin
      if (m_we)
        for (int i = 0; i < (1 << m_size[1:0]); i++) mm[(m_addr + i) % N] = m_wd[8*i +: 8];
      ph = 2;
    end else if (rsp_ready_i) ph = 0;
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("we_in_rst", {31'h0, mem_we_o}, 32'h0);
      chk("re_in_rst", {31'h0, mem_re_o}, 32'h0);
    end else begin
      chk("req_ready", {31'h0, req_ready_o}, {31'h0, ph == 0});
      chk("rsp_valid", {31'h0, rsp_valid_o}, {31'h0, ph == 2});
      chk("mem_we", {31'h0, mem_we_o}, {31'h0, ph == 1 && m_we});
      chk("mem_re", {31'h0, mem_re_o}, {31'h0, ph == 1 && !m_we});
      if (ph == 1) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_size", {29'h0, mem_size_o}, {29'h0, m_size});
        chk("mem_data", mem_data_o, m_wd);
      end
      if (ph == 2) begin
        chk("rsp_rdata", rsp_rdata_o, m_rd);
        chk("rsp_err", {30'h0, rsp_err_o}, {30'h0, m_err});
        chk("rsp_badaddr", rsp_badaddr_o, m_bad);
      end
    end
  end

  task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd, output logic [1:0] er,
                      output logic [31:0] ba, output int lat);
    logic seen;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_addr_i = a; req_wdata_i = wd;
    rsp_ready_i = (hold == 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid_o;
    end
    chk("rsp_timeout", {31'h0, seen}, 32'h1);
    rd = rsp_rdata_o; er = rsp_err_o; ba = rsp_badaddr_o;
    if (hold > 0) begin
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 3'b010; req_addr_i = 32'h10; req_wdata_i = 32'hBAD0BAD0;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_rdata_stable", rsp_rdata_o, rd);
        chk("bp_ready_low", {31'h0, req_ready_o}, 32'h0);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, ba;
    logic [1:0] er;
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, ba, lat);
    chk("sw_err", {30'h0, er}, 32'h0);
    chk("sw_lat", lat, 2);
    chk("sw_rdata", rd, 32'h0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, ba, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 2);
    xact(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er, ba, lat);
    chk("lb_rdata", rd, 32'hFFFFFFDE);
    xact(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er, ba, lat);
    chk("lbu_rdata", rd, 32'h000000DE);
    xact(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er, ba, lat);
    chk("lh_rdata", rd, 32'hFFFFDEAD);
    xact(1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er, ba, lat);
    chk("lhu_rdata", rd, 32'h0000BEEF);
    xact(1'b0, 3'b010, 32'h12, 32'h0, 0, rd, er, ba, lat);
    chk("mis_err", {30'h0, er}, 32'h1);
    chk("mis_bad", ba, 32'h12);
    chk("mis_lat", lat, 1);
    xact(1'b0, 3'b011, 32'h0, 32'h0, 0, rd, er, ba, lat);
    chk("sz011_err", {30'h0, er}, 32'h1);
    xact(1'b1, 3'b100, 32'h4, 32'h77, 0, rd, er, ba, lat);
    chk("sbu_err", {30'h0, er}, 32'h1);
    xact(1'b0, 3'b010, 32'h1FFC, 32'h0, 0, rd, er, ba, lat);
    chk("top_err", {30'h0, er}, 32'h0);
    xact(1'b0, 3'b010, 32'h2000, 32'h0, 0, rd, er, ba, lat);
    chk("oor_err", {30'h0, er}, 32'h2);
    chk("oor_bad", ba, 32'h2000);
    xact(1'b0, 3'b001, 32'h1FFF, 32'h0, 0, rd, er, ba, lat);
    chk("prio_err", {30'h0, er}, 32'h1);
    xact(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0, rd, er, ba, lat);
    chk("wrap_err", {30'h0, er}, 32'h2);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, ba, lat);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, ba, lat);
    chk("bp_ignored", rd, 32'hDEADBEEF);
    xact(1'b1, 3'b010, 32'h20, 32'h11223344, 0, rd, er, ba, lat);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 3'b010; req_addr_i = 32'h20; req_wdata_i = 32'h55;
    @(posedge clk); #1;
    req_valid_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_access_we", {31'h0, mem_we_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst2_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst2_err", {30'h0, rsp_err_o}, 32'h0);
    chk("rst2_bad", rsp_badaddr_o, 32'h0);
    chk("rst2_maddr", mem_addr_o, 32'h0);
    chk("rst2_mdata", mem_data_o, 32'h0);
    chk("rst2_msize", {29'h0, mem_size_o}, 32'h0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, ba, lat);
    chk("rst_nowrite", rd, 32'h11223344);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
